// File: rtl/salvo_scorer.sv
// Sequential shot scorer: scans a single cell or a (2R+1)^2 footprint against a fixed fleet, one cell per clock.
// Latency: result_valid pulses S+1 clocks after acceptance (S=1 single, S=K big); error results pulse after 1 clock.
// Backpressure: shot_ready is high only in IDLE; new_game aborts any scan and blocks acceptance that cycle.
module salvo_scorer #(
  parameter int COORD_W    = 4,
  parameter int BOARD_MAX  = 10,
  parameter int BIG_RADIUS = 1,
  parameter int BIG_BOMBS  = 3,
  localparam int D     = 2*BIG_RADIUS+1,
  localparam int K     = D*D,
  localparam int HIT_W = $clog2(K+1),
  localparam int BL_W  = $clog2(BIG_BOMBS+1)
) (
  input  logic               clock,
  input  logic               reset_N,
  input  logic               new_game,
  input  logic               shot_valid,
  output logic               shot_ready,
  input  logic [COORD_W-1:0] shot_x,
  input  logic [COORD_W-1:0] shot_y,
  input  logic               shot_big,
  output logic               result_valid,
  output logic               result_error,
  output logic               result_hit,
  output logic               result_near_miss,
  output logic               result_miss,
  output logic [HIT_W-1:0]   result_new_hits,
  output logic [4:0]         result_biggest,
  output logic [5:0]         sunk,
  output logic               game_over,
  output logic [BL_W-1:0]    big_left,
  output logic [7:0]         shots_taken
);

  localparam int SW    = COORD_W+1;
  localparam int NCELL = 19;
  localparam logic [4:0] NONE = 5'h1f;
  localparam logic [COORD_W-1:0] BMAX = COORD_W'(BOARD_MAX);
  localparam logic signed [SW-1:0] LASTO = SW'(D-1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  // Bitmap index of the fleet cell at (x,y), or NONE. Cells are grouped per ship:
  // carrier 0-4, battleship 5-8, cruiser 9-11, sub 12-14, patrol1 15-16, patrol2 17-18.
  function automatic logic [4:0] cell_idx(input int x, input int y);
    logic [4:0] i;
    i = NONE;
    if (x >= 1 && x <= BOARD_MAX && y >= 1 && y <= BOARD_MAX) begin
      if (y == 3 && x >= 2 && x <= 6)       i = 5'(x - 2);
      else if (y == 2 && x >= 1 && x <= 4)  i = 5'(x + 4);
      else if (y == 1 && x >= 2 && x <= 4)  i = 5'(x + 7);
      else if (x == 2 && y >= 8 && y <= 10) i = 5'(y + 4);
      else if (y == 6 && x >= 7 && x <= 8)  i = 5'(x + 8);
      else if (y == 1 && x >= 9 && x <= 10) i = 5'(x + 8);
    end
    return i;
  endfunction

  // Ship class one-hot of a bitmap index (both patrols share the lowest class).
  function automatic logic [4:0] cls_of(input logic [4:0] i);
    if (i <= 5'd4)       return 5'b10000;
    else if (i <= 5'd8)  return 5'b01000;
    else if (i <= 5'd11) return 5'b00100;
    else if (i <= 5'd14) return 5'b00010;
    else if (i <= 5'd18) return 5'b00001;
    else                 return 5'b00000;
  endfunction

  // Keep only the most significant class seen.
  function automatic logic [4:0] top_cls(input logic [4:0] c);
    if (c[4])      return 5'b10000;
    else if (c[3]) return 5'b01000;
    else if (c[2]) return 5'b00100;
    else if (c[1]) return 5'b00010;
    else if (c[0]) return 5'b00001;
    else           return 5'b00000;
  endfunction

  state_t                  state, state_nxt;
  logic                    accept, bad, last;
  logic                    big_q;
  logic signed [SW-1:0]    bx, by, ox, oy, cx, cy;
  logic [NCELL-1:0]        bm, bm_nxt;
  logic                    acc_hit;
  logic [HIT_W-1:0]        acc_new;
  logic [4:0]              acc_cls;
  logic [4:0]              cur_idx, cls_tot;
  logic                    cur_ship, newhit, nbr, hit_tot;
  logic [5:0]              sunk_nxt;

  // State register.
  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state, acceptance and handshake outputs.
  always_comb begin
    state_nxt    = state;
    accept       = 1'b0;
    last         = 1'b0;
    shot_ready   = (state == IDLE);
    result_valid = (state == DONE);
    bad = (shot_x == '0) || (shot_x > BMAX) || (shot_y == '0) || (shot_y > BMAX) ||
          (shot_big && big_left == '0);
    case (state)
      IDLE: if (shot_valid && !new_game) begin
        accept    = 1'b1;
        state_nxt = bad ? DONE : SCAN;
      end
      SCAN: begin
        last = !big_q || (ox == LASTO && oy == LASTO);
        if (last) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (new_game) state_nxt = IDLE;
  end

  // Evaluate the current footprint cell and its effect on the bitmap.
  always_comb begin
    cx       = bx + ox;
    cy       = by + oy;
    cur_idx  = cell_idx(int'(cx), int'(cy));
    cur_ship = (cur_idx != NONE);
    nbr      = (cell_idx(int'(cx) - 1, int'(cy)) != NONE) || (cell_idx(int'(cx) + 1, int'(cy)) != NONE) ||
               (cell_idx(int'(cx), int'(cy) - 1) != NONE) || (cell_idx(int'(cx), int'(cy) + 1) != NONE);
    bm_nxt   = bm;
    newhit   = 1'b0;
    if (state == SCAN && cur_ship) begin
      newhit          = ~bm[cur_idx];
      bm_nxt[cur_idx] = 1'b1;
    end
    hit_tot  = acc_hit | cur_ship;
    cls_tot  = acc_cls | cls_of(cur_idx);
    sunk_nxt = {&bm_nxt[4:0], &bm_nxt[8:5], &bm_nxt[11:9], &bm_nxt[14:12], &bm_nxt[16:15], &bm_nxt[18:17]};
  end

  // Shot capture, scan accumulation, result registers and game bookkeeping.
  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      big_q <= 1'b0; bx <= '0; by <= '0; ox <= '0; oy <= '0;
      bm <= '0; acc_hit <= 1'b0; acc_new <= '0; acc_cls <= '0;
      result_error <= 1'b0; result_hit <= 1'b0; result_near_miss <= 1'b0; result_miss <= 1'b0;
      result_new_hits <= '0; result_biggest <= '0;
      sunk <= '0; game_over <= 1'b0;
      big_left <= BL_W'(BIG_BOMBS); shots_taken <= '0;
    end else if (new_game) begin
      acc_hit <= 1'b0; acc_new <= '0; acc_cls <= '0;
      bm <= '0;
      result_error <= 1'b0; result_hit <= 1'b0; result_near_miss <= 1'b0; result_miss <= 1'b0;
      result_new_hits <= '0; result_biggest <= '0;
      sunk <= '0; game_over <= 1'b0;
      big_left <= BL_W'(BIG_BOMBS); shots_taken <= '0;
    end else begin
      bm <= bm_nxt;
      if (accept) begin
        big_q   <= shot_big;
        bx      <= $signed({1'b0, shot_x}) - (shot_big ? SW'(BIG_RADIUS) : SW'(0));
        by      <= $signed({1'b0, shot_y}) - (shot_big ? SW'(BIG_RADIUS) : SW'(0));
        ox      <= '0;
        oy      <= '0;
        acc_hit <= 1'b0; acc_new <= '0; acc_cls <= '0;
        if (bad) begin
          result_error <= 1'b1; result_hit <= 1'b0; result_near_miss <= 1'b0; result_miss <= 1'b0;
          result_new_hits <= '0; result_biggest <= '0;
          sunk      <= sunk_nxt;
          game_over <= &sunk_nxt;
        end else begin
          if (shots_taken != 8'hff) shots_taken <= shots_taken + 8'd1;
          if (shot_big) big_left <= big_left - BL_W'(1);
        end
      end
      if (state == SCAN) begin
        acc_hit <= hit_tot;
        acc_new <= acc_new + HIT_W'(newhit);
        acc_cls <= cls_tot;
        if (ox == LASTO) begin
          ox <= '0;
          oy <= oy + SW'(1);
        end else begin
          ox <= ox + SW'(1);
        end
        if (last) begin
          result_error     <= 1'b0;
          result_hit       <= hit_tot;
          result_near_miss <= !big_q && !hit_tot && nbr;
          result_miss      <= !hit_tot && !(!big_q && nbr);
          result_new_hits  <= acc_new + HIT_W'(newhit);
          result_biggest   <= top_cls(cls_tot);
          sunk             <= sunk_nxt;
          game_over        <= &sunk_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_salvo_scorer.sv
// Bench for salvo_scorer: randomized and directed shots scored by a cell-list fleet model.
// Latency: expected results queued at issue and matched by a monitor with their due cycle.
// Backpressure: driver waits for shot_ready before each shot, bounded by a cycle budget.
module tb_salvo_scorer;

  localparam int K   = 9;
  localparam int R   = 1;
  localparam int BMX = 10;

  logic       clock = 1'b0, reset_N = 1'b0, new_game = 1'b0;
  logic       shot_valid = 1'b0, shot_big = 1'b0;
  logic [3:0] shot_x = '0, shot_y = '0;
  logic       shot_ready, result_valid, result_error, result_hit, result_near_miss, result_miss;
  logic [3:0] result_new_hits;
  logic [4:0] result_biggest;
  logic [5:0] sunk;
  logic       game_over;
  logic [1:0] big_left;
  logic [7:0] shots_taken;

  salvo_scorer dut (
    .clock(clock), .reset_N(reset_N), .new_game(new_game),
    .shot_valid(shot_valid), .shot_ready(shot_ready),
    .shot_x(shot_x), .shot_y(shot_y), .shot_big(shot_big),
    .result_valid(result_valid), .result_error(result_error), .result_hit(result_hit),
    .result_near_miss(result_near_miss), .result_miss(result_miss),
    .result_new_hits(result_new_hits), .result_biggest(result_biggest),
    .sunk(sunk), .game_over(game_over), .big_left(big_left), .shots_taken(shots_taken)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  int nchecks = 0;
  int errors  = 0;

  typedef struct {
    bit err, hit, near, miss, go;
    int newh, bigl, shots, due;
    logic [4:0] big;
    logic [5:0] sunk;
  } exp_t;
  exp_t sbq[$];

  // Fleet as ship list: start cell, length, orientation. Order = carrier .. patrol2.
  int sx0[6]   = '{2, 1, 2, 2, 7, 9};
  int sy0[6]   = '{3, 2, 1, 8, 6, 1};
  int slen[6]  = '{5, 4, 3, 3, 2, 2};
  bit svert[6] = '{0, 0, 0, 1, 0, 0};

  int mark[16][16];
  int m_shots, m_bigl;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    nchecks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic int ship_at(input int x, input int y);
    for (int s = 0; s < 6; s++)
      for (int i = 0; i < slen[s]; i++)
        if (x == sx0[s] + (svert[s] ? 0 : i) && y == sy0[s] + (svert[s] ? i : 0)) return s + 1;
    return 0;
  endfunction

  function automatic logic [5:0] model_sunk();
    logic [5:0] r = '0;
    for (int s = 0; s < 6; s++) begin
      int cnt = 0;
      for (int i = 0; i < slen[s]; i++)
        cnt += mark[sx0[s] + (svert[s] ? 0 : i)][sy0[s] + (svert[s] ? i : 0)];
      if (cnt == slen[s]) r[5 - s] = 1'b1;
    end
    return r;
  endfunction

  task automatic model_clear();
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++) mark[x][y] = 0;
    m_shots = 0;
    m_bigl  = 3;
  endtask

  task automatic model_shot(input int x, input int y, input bit big, output exp_t e);
    int best = 7;
    int r    = big ? R : 0;
    e.err = (x < 1 || x > BMX || y < 1 || y > BMX || (big && m_bigl == 0));
    e.hit = 0; e.near = 0; e.miss = 0; e.newh = 0; e.big = '0;
    if (e.err) begin
      e.due = cyc + 1;
    end else begin
      m_shots = (m_shots < 255) ? m_shots + 1 : 255;
      if (big) m_bigl--;
      for (int dy = -r; dy <= r; dy++)
        for (int dx = -r; dx <= r; dx++) begin
          int px = x + dx, py = y + dy, s;
          if (px >= 1 && px <= BMX && py >= 1 && py <= BMX) begin
            s = ship_at(px, py);
            if (s > 0) begin
              e.hit = 1;
              if (s < best) best = s;
              if (mark[px][py] == 0) begin
                mark[px][py] = 1;
                e.newh++;
              end
            end
          end
        end
      e.near = !big && !e.hit &&
               (ship_at(x - 1, y) > 0 || ship_at(x + 1, y) > 0 || ship_at(x, y - 1) > 0 || ship_at(x, y + 1) > 0);
      e.miss = !e.hit && !e.near;
      if (best <= 4)      e.big = 5'b00001 << (5 - best);
      else if (best <= 6) e.big = 5'b00001;
      e.due = cyc + (big ? K + 1 : 2);
    end
    e.sunk  = model_sunk();
    e.go    = &e.sunk;
    e.bigl  = m_bigl;
    e.shots = m_shots;
  endtask

  // Called just after a negedge; returns just after the negedge following acceptance.
  task automatic fire(input int x, input int y, input bit big, input bit expect_res);
    exp_t e;
    int n = 0;
    while (!shot_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (!shot_ready) begin
      chk("ready_timeout", 32'(shot_ready), 1);
      return;
    end
    shot_valid = 1'b1;
    shot_x     = 4'(x);
    shot_y     = 4'(y);
    shot_big   = big;
    model_shot(x, y, big, e);
    if (expect_res) sbq.push_back(e);
    @(negedge clock);
    shot_valid = 1'b0;
    shot_x     = 4'($urandom);
    shot_y     = 4'($urandom);
    shot_big   = 1'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((!shot_ready || sbq.size() != 0) && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk("idle_wait", 32'(sbq.size()), 0);
  endtask

  task automatic do_new_game();
    new_game = 1'b1;
    @(negedge clock);
    new_game = 1'b0;
    model_clear();
  endtask

  // Monitor: every result pulse is matched to the oldest expected response.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset_N && result_valid) begin
        if (sbq.size() == 0) begin
          chk("unexpected_result", 32'(result_valid), 0);
        end else begin
          e = sbq.pop_front();
          chk("latency",     cyc, e.due);
          chk("res_error",   32'(result_error), 32'(e.err));
          chk("res_hit",     32'(result_hit), 32'(e.hit));
          chk("res_near",    32'(result_near_miss), 32'(e.near));
          chk("res_miss",    32'(result_miss), 32'(e.miss));
          chk("res_newhits", 32'(result_new_hits), e.newh);
          chk("res_biggest", 32'(result_biggest), 32'(e.big));
          chk("sunk",        32'(sunk), 32'(e.sunk));
          chk("game_over",   32'(game_over), 32'(e.go));
          chk("big_left",    32'(big_left), e.bigl);
          chk("shots_taken", 32'(shots_taken), e.shots);
        end
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

  initial begin : stim
    model_clear();
    repeat (3) @(negedge clock);
    chk("rst_ready",   32'(shot_ready), 1);
    chk("rst_valid",   32'(result_valid), 0);
    chk("rst_hit",     32'(result_hit), 0);
    chk("rst_error",   32'(result_error), 0);
    chk("rst_newhits", 32'(result_new_hits), 0);
    chk("rst_biggest", 32'(result_biggest), 0);
    chk("rst_sunk",    32'(sunk), 0);
    chk("rst_go",      32'(game_over), 0);
    chk("rst_bigl",    32'(big_left), 3);
    chk("rst_shots",   32'(shots_taken), 0);
    reset_N = 1'b1;
    @(negedge clock);

    // Directed: hits, repeat hit, big shot sinking the cruiser, near miss, miss, edge big shot, error.
    fire(3, 3, 0, 1);
    fire(3, 3, 0, 1);
    fire(3, 2, 1, 1);
    fire(1, 1, 0, 1);
    fire(8, 9, 0, 1);
    fire(1, 1, 1, 1);
    fire(0, 5, 0, 1);
    fire(5, 11, 0, 1);
    fire(10, 10, 1, 1);

    // Bomb inventory exhaustion.
    wait_idle();
    do_new_game();
    fire(5, 5, 1, 1);
    fire(9, 9, 1, 1);
    fire(2, 9, 1, 1);
    fire(7, 6, 1, 1);
    wait_idle();
    chk("bigl_empty", 32'(big_left), 0);

    // new_game in the fourth scan cycle aborts the shot.
    do_new_game();
    fire(3, 3, 1, 0);
    repeat (3) @(negedge clock);
    new_game = 1'b1;
    @(negedge clock);
    new_game = 1'b0;
    model_clear();
    chk("abort_ready", 32'(shot_ready), 1);
    chk("abort_valid", 32'(result_valid), 0);
    chk("abort_bigl",  32'(big_left), 3);
    chk("abort_shots", 32'(shots_taken), 0);
    repeat (12) @(negedge clock);
    fire(3, 3, 0, 1);

    // Asynchronous reset in the middle of a big scan.
    wait_idle();
    fire(2, 2, 1, 0);
    repeat (3) @(negedge clock);
    #2 reset_N = 1'b0;
    #1;
    chk("areset_hit",   32'(result_hit), 0);
    chk("areset_new",   32'(result_new_hits), 0);
    chk("areset_shots", 32'(shots_taken), 0);
    chk("areset_bigl",  32'(big_left), 3);
    chk("areset_ready", 32'(shot_ready), 1);
    @(negedge clock);
    reset_N = 1'b1;
    model_clear();
    @(negedge clock);

    // Sink the whole fleet, then keep shooting.
    fire(3, 2, 1, 1);
    for (int s = 0; s < 6; s++)
      for (int i = 0; i < slen[s]; i++)
        fire(sx0[s] + (svert[s] ? 0 : i), sy0[s] + (svert[s] ? i : 0), 0, 1);
    fire(5, 5, 0, 1);
    wait_idle();
    chk("go_hold",  32'(game_over), 1);
    chk("sunk_all", 32'(sunk), 32'h3f);

    // Randomized shots, including off-board coordinates and big shots.
    for (int n = 0; n < 80; n++) begin
      if (n % 20 == 0) begin
        wait_idle();
        do_new_game();
      end
      fire(int'($urandom_range(0, 12)), int'($urandom_range(0, 12)), ($urandom_range(0, 3) == 0), 1);
    end

    wait_idle();
    chk("drain", 32'(sbq.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, nchecks);
    $finish;
  end

endmodule
